// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI frame scheduler.
package spi_sched_pkg;

    localparam int unsigned SPI_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        RESPOND   = 3'd3,
        GAP       = 3'd4
    } sched_state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1.
module rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            idx = (32'(last) + i) % NREQ;
            if (req[IDW'(idx)]) begin
                gnt_id = IDW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Round-robin scheduler sharing one spi_master between NREQ requesters,
// with inter-frame gap and transfer timeout.
module spi_frame_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned IDW        = 2,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SPI_W-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [SPI_W-1:0]      rsp_data,
    output logic                  err,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  spi_start,
    output logic [SPI_W-1:0]      spi_tx_data,
    input  logic                  spi_done,
    input  logic [SPI_W-1:0]      spi_rx_data
);

    localparam int unsigned TCNT_W   = clog2(TIMEOUT) + 1;
    localparam int unsigned GCNT_W   = (clog2(GAP_CYCLES + 1) > 0) ? clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sched_state_e      state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    logic [NREQ-1:0]   ack_d;
    logic [SPI_W-1:0]  rsp_d;
    logic              err_d;
    logic              busy_d;
    logic [IDW-1:0]    grant_d;
    logic              start_d;
    logic [SPI_W-1:0]  tx_d;

    logic [IDW-1:0]    arb_gnt;
    logic              arb_any;

    // grant_id doubles as the last-grant pointer for the arbiter.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .last   (grant_id),
        .gnt_id (arb_gnt),
        .any    (arb_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        ack_d   = '0;
        rsp_d   = rsp_data;
        err_d   = err;
        grant_d = grant_id;
        start_d = 1'b0;
        tx_d    = spi_tx_data;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (arb_gnt == IDW'(i)) begin
                            tx_d = req_data[i*SPI_W +: SPI_W];
                        end
                    end
                    start_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tcnt_d  = tcnt_q + 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                tcnt_d = tcnt_q + 1'b1;
                // Counter holds cycles since spi_start; done beats timeout.
                if (spi_done) begin
                    rsp_d           = spi_rx_data;
                    err_d           = 1'b0;
                    ack_d[grant_id] = 1'b1;
                    state_d         = RESPOND;
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    rsp_d           = '0;
                    err_d           = 1'b1;
                    ack_d[grant_id] = 1'b1;
                    state_d         = RESPOND;
                end
            end
            RESPOND: begin
                gcnt_d  = '0;
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gcnt_q == GCNT_W'(GAP_LAST)) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
            ack         <= '0;
            rsp_data    <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= IDW'(NREQ - 1);
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            gcnt_q      <= gcnt_d;
            ack         <= ack_d;
            rsp_data    <= rsp_d;
            err         <= err_d;
            busy        <= busy_d;
            grant_id    <= grant_d;
            spi_start   <= start_d;
            spi_tx_data <= tx_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench for spi_frame_scheduler; the bench plays the spi_master.
module tb_spi_frame_scheduler;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned GAP     = 8;
    localparam int unsigned TMO     = 64;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [31:0]       rsp_data;
    logic              err;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              spi_start;
    logic [31:0]       spi_tx_data;
    logic              spi_done;
    logic [31:0]       spi_rx_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    spi_frame_scheduler #(
        .NREQ       (NREQ),
        .IDW        (IDW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .rsp_data    (rsp_data),
        .err         (err),
        .busy        (busy),
        .grant_id    (grant_id),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (spi_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, spi_start, err, ack} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b start=%b err=%b ack=%b, want all 0", busy, spi_start, err, ack);
        end
        vectors++;
        if (grant_id !== 2'd3 || spi_tx_data !== 32'h0 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got gid=%0d tx=%h rsp=%h, want 3/0/0", grant_id, spi_tx_data, rsp_data);
        end
    endtask

    task automatic test_single();
        req_data = '0;
        req_data[31:0] = 32'hDEADBEEF;
        req = 4'b0001;
        vectors++;
        if (spi_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pre_start: got %b want 0", spi_start);
        end
        tick();
        vectors++;
        if (spi_start !== 1'b1 || spi_tx_data !== 32'hDEADBEEF || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_launch: got start=%b tx=%h gid=%0d want 1/deadbeef/0", spi_start, spi_tx_data, grant_id);
        end
        tick();
        vectors++;
        if (spi_start !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start_width: got start=%b busy=%b want 0/1", spi_start, busy);
        end
        repeat (39) tick();
        spi_done = 1'b1;
        spi_rx_data = 32'h12345678;
        tick();
        spi_done = 1'b0;
        req = 4'b0000;
        vectors++;
        if (ack !== 4'b0001 || rsp_data !== 32'h12345678 || err !== 1'b0 || spi_tx_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b rsp=%h err=%b tx=%h want 0001/12345678/0/deadbeef", ack, rsp_data, err, spi_tx_data);
        end
        tick();
        vectors++;
        if (ack !== 4'b0000 || rsp_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL single_ack_once: got ack=%b rsp=%h want 0000/12345678", ack, rsp_data);
        end
        repeat (GAP - 1) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_gap_busy: got %b want 1", busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gap_end: got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] words [4];
        int unsigned last_start;
        int unsigned exp;
        bit ok;
        words[0] = 32'hA0A0_0000;
        words[1] = 32'hB1B1_1111;
        words[2] = 32'hC2C2_2222;
        words[3] = 32'hD3D3_3333;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = words[i];
        req = 4'b1111;
        last_start = 0;
        for (int f = 0; f < 6; f++) begin
            exp = f % 4;
            wait_start(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rr_start_timeout: frame %0d no spi_start", f);
                break;
            end
            vectors++;
            if (grant_id !== IDW'(exp) || spi_tx_data !== words[exp]) begin
                miscompares++;
                $display("FAIL rr_grant: frame %0d got gid=%0d tx=%h want %0d/%h", f, grant_id, spi_tx_data, exp, words[exp]);
            end
            if (f > 0) begin
                vectors++;
                if (cyc - last_start !== 5 + 3 + GAP) begin
                    miscompares++;
                    $display("FAIL rr_spacing: frame %0d got %0d want %0d", f, cyc - last_start, 5 + 3 + GAP);
                end
            end
            last_start = cyc;
            repeat (5) tick();
            spi_done = 1'b1;
            spi_rx_data = 32'h5000_0000 + 32'(f);
            tick();
            spi_done = 1'b0;
            vectors++;
            if (ack !== (4'b0001 << exp) || rsp_data !== 32'h5000_0000 + 32'(f)) begin
                miscompares++;
                $display("FAIL rr_ack: frame %0d got ack=%b rsp=%h want %b/%h", f, ack, rsp_data, 4'b0001 << exp, 32'h5000_0000 + 32'(f));
            end
            tick();
        end
        req = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        int unsigned s;
        bit ok;
        bit got;
        req_data[95:64] = 32'h7777_0002;
        req = 4'b0100;
        wait_start(ok);
        s = cyc;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ack != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        req = 4'b0000;
        vectors++;
        if (!got || cyc - s !== TMO) begin
            miscompares++;
            $display("FAIL timeout_latency: got ack=%b after %0d cycles want %0d", got, cyc - s, TMO);
        end
        vectors++;
        if (ack !== 4'b0100 || err !== 1'b1 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_ack: got ack=%b err=%b rsp=%h want 0100/1/0", ack, err, rsp_data);
        end
        wait_idle(ok);
        req_data[63:32] = 32'h1111_2222;
        req = 4'b0010;
        wait_start(ok);
        vectors++;
        if (!ok || spi_tx_data !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL after_timeout_start: got ok=%b tx=%h want 1/11112222", ok, spi_tx_data);
        end
        repeat (10) tick();
        spi_done = 1'b1;
        spi_rx_data = 32'hCAFEF00D;
        tick();
        spi_done = 1'b0;
        req = 4'b0000;
        vectors++;
        if (ack !== 4'b0010 || err !== 1'b0 || rsp_data !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL after_timeout_ack: got ack=%b err=%b rsp=%h want 0010/0/cafef00d", ack, err, rsp_data);
        end
        wait_idle(ok);
    endtask

    task automatic test_collision();
        int unsigned s;
        bit ok;
        req_data[31:0] = 32'h0BAD_0001;
        req = 4'b0001;
        wait_start(ok);
        s = cyc;
        repeat (TMO - 1) tick();
        spi_done = 1'b1;
        spi_rx_data = 32'hA5A5_5A5A;
        tick();
        spi_done = 1'b0;
        req = 4'b0000;
        vectors++;
        if (ack !== 4'b0001 || err !== 1'b0 || rsp_data !== 32'hA5A5_5A5A || cyc - s !== TMO) begin
            miscompares++;
            $display("FAIL collision: got ack=%b err=%b rsp=%h dt=%0d want 0001/0/a5a55a5a/%0d", ack, err, rsp_data, cyc - s, TMO);
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int unsigned bad;
        req_data[127:96] = 32'h3333_4444;
        req = 4'b1000;
        wait_start(ok);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0000;
        vectors++;
        if (busy !== 1'b0 || spi_tx_data !== 32'h0 || grant_id !== 2'd3 || ack !== 4'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b tx=%h gid=%0d ack=%b want 0/0/3/0", busy, spi_tx_data, grant_id, ack);
        end
        spi_done = 1'b1;
        spi_rx_data = 32'hFFFF_0000;
        tick();
        spi_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (ack !== 4'b0 || busy !== 1'b0 || spi_start !== 1'b0 || rsp_data !== 32'h0) bad++;
            tick();
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL late_done: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_stray_and_drop();
        bit ok;
        int unsigned bad;
        spi_done = 1'b1;
        spi_rx_data = 32'h9999_9999;
        tick();
        spi_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack !== 4'b0 || busy !== 1'b0 || err !== 1'b0 || rsp_data !== 32'h0) bad++;
            tick();
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL stray_done: got %0d bad cycles want 0", bad);
        end
        req_data[63:32] = 32'h0D0D_0D0D;
        req = 4'b0010;
        wait_start(ok);
        vectors++;
        if (!ok || grant_id !== 2'd1) begin
            miscompares++;
            $display("FAIL drop_grant: got ok=%b gid=%0d want 1/1", ok, grant_id);
        end
        repeat (3) tick();
        req = 4'b0000;
        repeat (7) tick();
        spi_done = 1'b1;
        spi_rx_data = 32'h0000_BEEF;
        tick();
        spi_done = 1'b0;
        vectors++;
        if (ack !== 4'b0010 || rsp_data !== 32'h0000_BEEF || err !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_ack: got ack=%b rsp=%h err=%b want 0010/0000beef/0", ack, rsp_data, err);
        end
        wait_idle(ok);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (spi_start !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (!ok || bad !== 0) begin
            miscompares++;
            $display("FAIL drop_no_regrant: got idle=%b bad=%0d want 1/0", ok, bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_data = '0;
        spi_done = 1'b0;
        spi_rx_data = '0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid_frame();
        test_stray_and_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
